// File: rtl/odd_parity_serial_rx_pkg.sv
// Shared definitions for the odd-parity serial link: receiver state encodings
// and the parity-bit helper also used on the transmit side.
package odd_parity_serial_rx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_BREAK  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP,
        S_BREAK  = ST_BREAK
    } rx_state_t;

    localparam int PAR_MAX_W = 64;

    // Parity bit that makes the total count of ones odd; zero-extension of
    // narrower words does not change the result.
    function automatic logic odd_parity_bit(input logic [PAR_MAX_W-1:0] v);
        return ~(^v);
    endfunction

endpackage

// File: rtl/odd_parity_serial_rx_calc.sv
// Combinational ones-count parity: o_odd is 1 when i_vec holds an odd number of ones.
module odd_parity_calc #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_vec,
    output logic         o_odd
);

    assign o_odd = ^i_vec;

endmodule

// File: rtl/odd_parity_serial_rx.sv
// Odd-parity serial receiver: deserialises start/data/parity/stop frames sampled
// on bit_en strobes and reports word, parity/framing status and an error count.
//
//   state  | meaning
//   IDLE   | line idle, waiting for a start bit (rx=0 on bit_en)
//   DATA   | sampling DATA_W data bits, LSB first
//   PARITY | sampling the parity bit
//   STOP   | sampling the stop bit; frame finishes here
//   BREAK  | stop bit was 0; waiting for the line to return high
module odd_parity_serial_rx
    import odd_parity_serial_rx_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_en,
    input  logic                 rx,
    input  logic                 clr_cnt,
    output logic [DATA_W-1:0]    data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [DATA_W-1:0]    r_shreg;
    logic [DATA_W-1:0]    w_shreg_nxt;
    logic                 r_par;
    logic [DATA_W-1:0]    r_data_out;
    logic                 r_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic                 w_odd;
    logic                 w_finish;
    logic                 w_frame_bad;

    odd_parity_calc #(
        .W (DATA_W + 1)
    ) u_parity (
        .i_vec ({r_shreg, r_par}),
        .o_odd (w_odd)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (bit_en) begin
            case (r_state)
                S_IDLE:   if (!rx) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == LAST_BIT) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP:   w_state_nxt = rx ? S_IDLE : S_BREAK;
                S_BREAK:  if (rx) w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_shreg_nxt = r_shreg;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == int'(r_bit_cnt)) w_shreg_nxt[i] = rx;
        end
    end

    assign w_finish    = bit_en && (r_state == S_STOP);
    assign w_frame_bad = ~w_odd | ~rx;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_par        <= 1'b0;
            r_data_out   <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_valid <= w_finish;
            if (bit_en) begin
                case (r_state)
                    S_IDLE: r_bit_cnt <= '0;
                    S_DATA: begin
                        r_shreg   <= w_shreg_nxt;
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                    S_PARITY: r_par <= rx;
                    default: ;
                endcase
            end
            if (w_finish) begin
                r_data_out   <= r_shreg;
                r_parity_err <= ~w_odd;
                r_frame_err  <= ~rx;
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_err_count <= '0;
        end else if (w_finish && w_frame_bad && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign data_out   = r_data_out;
    assign valid      = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE);
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_odd_parity_serial_rx.sv
// Directed, table-driven bench for odd_parity_serial_rx with DATA_W=4, ERR_CNT_W=8.
module tb_odd_parity_serial_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_en = 1'b0;
    logic       rx = 1'b1;
    logic       clr_cnt = 1'b0;
    logic [3:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [7:0] err_count;

    int total = 0;
    int bad = 0;

    odd_parity_serial_rx #(
        .DATA_W    (4),
        .ERR_CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .rx         (rx),
        .clr_cnt    (clr_cnt),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Valid observer on the falling edge.
    int         cyc = 0;
    int         vcount = 0;
    int         last_vcyc = 0;
    int         prev_vcyc = 0;
    logic [3:0] last_vdata = '0;
    logic [3:0] prev_vdata = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (valid) begin
            vcount     <= vcount + 1;
            prev_vcyc  <= last_vcyc;
            last_vcyc  <= cyc;
            prev_vdata <= last_vdata;
            last_vdata <= data_out;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap, input logic clr);
        rx = b;
        bit_en = 1'b0;
        for (int k = 1; k < gap; k++) tick();
        bit_en  = 1'b1;
        clr_cnt = clr;
        tick();
        bit_en  = 1'b0;
        clr_cnt = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic stop,
                              input int gap, input logic clr_on_stop);
        send_bit(1'b0, gap, 1'b0);
        for (int k = 0; k < 4; k++) send_bit(d[k], gap, 1'b0);
        send_bit(p, gap, 1'b0);
        send_bit(stop, gap, clr_on_stop);
    endtask

    typedef struct {
        logic [3:0] data;
        logic       par;
        logic [3:0] exp_data;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[8];
    int   exp_cnt;
    int   v0;

    initial begin
        vecs[0] = '{4'hD, 1'b0, 4'hD, 1'b0};
        vecs[1] = '{4'hD, 1'b1, 4'hD, 1'b1};
        vecs[2] = '{4'h0, 1'b1, 4'h0, 1'b0};
        vecs[3] = '{4'hF, 1'b1, 4'hF, 1'b0};
        vecs[4] = '{4'hF, 1'b0, 4'hF, 1'b1};
        vecs[5] = '{4'h5, 1'b1, 4'h5, 1'b0};
        vecs[6] = '{4'h7, 1'b0, 4'h7, 1'b0};
        vecs[7] = '{4'h8, 1'b1, 4'h8, 1'b1};

        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_perr", 32'(parity_err), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cnt", 32'(err_count), 32'h0);

        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, vecs[i].par, 1'b1, 4, 1'b0);
            if (vecs[i].exp_perr) exp_cnt++;
            chk($sformatf("v%0d_valid", i), 32'(valid), 32'h1);
            chk($sformatf("v%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_perr", i), 32'(parity_err), 32'(vecs[i].exp_perr));
            chk($sformatf("v%0d_ferr", i), 32'(frame_err), 32'h0);
            chk($sformatf("v%0d_cnt", i), 32'(err_count), 32'(exp_cnt));
            tick();
            chk($sformatf("v%0d_vdrop", i), 32'(valid), 32'h0);
            chk($sformatf("v%0d_hold", i), 32'(parity_err), 32'(vecs[i].exp_perr));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
        end

        // Stop bit low, line held low, then released.
        v0 = vcount;
        send_frame(4'h0, 1'b1, 1'b0, 4, 1'b0);
        exp_cnt++;
        chk("brk_valid", 32'(valid), 32'h1);
        chk("brk_ferr", 32'(frame_err), 32'h1);
        chk("brk_perr", 32'(parity_err), 32'h0);
        chk("brk_cnt", 32'(err_count), 32'(exp_cnt));
        send_bit(1'b0, 4, 1'b0);
        send_bit(1'b0, 4, 1'b0);
        chk("brk_busy", 32'(busy), 32'h1);
        send_bit(1'b1, 4, 1'b0);
        tick();
        chk("brk_idle", 32'(busy), 32'h0);
        chk("brk_one_valid", 32'(vcount), 32'(v0 + 1));

        // Reset in the middle of a frame.
        v0 = vcount;
        send_bit(1'b0, 4, 1'b0);
        send_bit(1'b0, 4, 1'b0);
        send_bit(1'b1, 4, 1'b0);
        chk("abort_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rx = 1'b1;
        tick();
        exp_cnt = 0;
        chk("abort_idle", 32'(busy), 32'h0);
        chk("abort_data", 32'(data_out), 32'h0);
        chk("abort_cnt", 32'(err_count), 32'h0);
        chk("abort_novalid", 32'(vcount), 32'(v0));
        send_frame(4'hA, 1'b1, 1'b1, 4, 1'b0);
        chk("after_valid", 32'(valid), 32'h1);
        chk("after_data", 32'(data_out), 32'hA);
        chk("after_perr", 32'(parity_err), 32'h0);
        chk("after_ferr", 32'(frame_err), 32'h0);
        tick();
        chk("after_one_valid", 32'(vcount), 32'(v0 + 1));

        // Saturation of the error counter, then clear vs increment.
        for (int i = 0; i < 300; i++) begin
            send_frame(4'h3, 1'b0, 1'b1, 1, 1'b0);
            if (i == 254) chk("sat_255", 32'(err_count), 32'hFF);
        end
        chk("sat_300", 32'(err_count), 32'hFF);
        send_frame(4'h3, 1'b0, 1'b1, 1, 1'b1);
        chk("clr_beats_inc", 32'(err_count), 32'h0);
        send_frame(4'h3, 1'b0, 1'b1, 1, 1'b0);
        chk("cnt_after_clr", 32'(err_count), 32'h1);
        tick();

        // Back-to-back frames with a strobe every clock.
        v0 = vcount;
        send_frame(4'h3, 1'b1, 1'b1, 1, 1'b0);
        send_frame(4'h6, 1'b1, 1'b1, 1, 1'b0);
        tick();
        chk("b2b_count", 32'(vcount), 32'(v0 + 2));
        chk("b2b_gap", 32'(last_vcyc - prev_vcyc), 32'd7);
        chk("b2b_data0", 32'(prev_vdata), 32'h3);
        chk("b2b_data1", 32'(last_vdata), 32'h6);
        chk("b2b_perr", 32'(parity_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
